// File: rtl/tone_pkg.sv
// Shared types and note-table helpers for the tone sequencer.
// The half-period table is built at elaboration time, so no run-time divider is inferred.
package tone_pkg;

  localparam int IDX_W    = 3;
  localparam int NOTE_CNT = 8;

  localparam int unsigned NOTE_HZ [NOTE_CNT] = '{523, 587, 659, 698, 783, 880, 987, 1046};

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  typedef logic [NOTE_CNT-1:0][31:0] note_table_t;

  function automatic note_table_t half_period_table(input int unsigned clk_hz);
    note_table_t t;
    for (int i = 0; i < NOTE_CNT; i++) begin
      t[i] = 32'(clk_hz / (2 * NOTE_HZ[i]));
    end
    return t;
  endfunction

endpackage

// File: rtl/note_rom.sv
// Constant lookup from note index to the divider half-period count.
module note_rom
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic [IDX_W-1:0] idx,
  output logic [31:0]      half_period
);

  localparam note_table_t TABLE = half_period_table(CLK_HZ);

  assign half_period = TABLE[idx];

endmodule

// File: rtl/tone_sequencer.sv
// Steps through an 8-note scale, gating a downstream clock divider with
// tone_en and supplying its half-period count.
//
// state | meaning
// IDLE  | silent, counter held at 0, next steps the note manually
// PLAY  | tone audible, counter runs toward NOTE_CYC when auto is set
// GAP   | silent pause between notes, counter runs toward GAP_CYC
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned NOTE_CYC = 25_000_000,
  parameter int unsigned GAP_CYC  = 2_500_000
) (
  input  logic             inclk,
  input  logic             reset,
  input  logic             play,
  input  logic             auto,
  input  logic             next,
  output logic [31:0]      div_clk_count,
  output logic             tone_en,
  output logic [IDX_W-1:0] note_idx,
  output logic             note_strobe
);

  localparam note_table_t TABLE     = half_period_table(CLK_HZ);
  localparam logic [31:0] DIV_RST   = TABLE[0];
  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

  state_t           state;
  logic [31:0]      cnt;
  logic [IDX_W-1:0] idx_inc;
  logic [31:0]      div_inc;

  // The ROM always looks one note ahead so index and count update on the same edge.
  assign idx_inc = note_idx + IDX_W'(1);

  note_rom #(.CLK_HZ(CLK_HZ)) u_note_rom (
    .idx         (idx_inc),
    .half_period (div_inc)
  );

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      note_idx      <= '0;
      div_clk_count <= DIV_RST;
      tone_en       <= 1'b0;
      note_strobe   <= 1'b0;
    end else begin
      note_strobe <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (play) begin
            state   <= PLAY;
            tone_en <= 1'b1;
          end else if (next) begin
            note_idx      <= idx_inc;
            div_clk_count <= div_inc;
            note_strobe   <= 1'b1;
          end
        end
        PLAY: begin
          if (!play) begin
            state   <= IDLE;
            cnt     <= '0;
            tone_en <= 1'b0;
          end else if (next || (auto && cnt == NOTE_LAST)) begin
            state   <= GAP;
            cnt     <= '0;
            tone_en <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GAP: begin
          if (!play) begin
            state   <= IDLE;
            cnt     <= '0;
            tone_en <= 1'b0;
          end else if (cnt == GAP_LAST) begin
            state         <= PLAY;
            cnt           <= '0;
            tone_en       <= 1'b1;
            note_idx      <= idx_inc;
            div_clk_count <= div_inc;
            note_strobe   <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          tone_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios plus randomized play/auto/next,
// with a timestamp-based reference model feeding a strobe scoreboard.
module tb_tone_sequencer;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned NOTE_CYC = 20;
  localparam int unsigned GAP_CYC  = 4;

  logic        inclk = 1'b0;
  logic        reset = 1'b1;
  logic        play  = 1'b0;
  logic        auto  = 1'b0;
  logic        next  = 1'b0;
  logic [31:0] div_clk_count;
  logic        tone_en;
  logic [2:0]  note_idx;
  logic        note_strobe;

  tone_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .NOTE_CYC (NOTE_CYC),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .inclk         (inclk),
    .reset         (reset),
    .play          (play),
    .auto          (auto),
    .next          (next),
    .div_clk_count (div_clk_count),
    .tone_en       (tone_en),
    .note_idx      (note_idx),
    .note_strobe   (note_strobe)
  );

  always #5 inclk = ~inclk;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned freq_hz  [8] = '{523, 587, 659, 698, 783, 880, 987, 1046};
  int unsigned spec_div [8] = '{47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900};

  function automatic int unsigned ref_div(input int n);
    return CLK_HZ / (2 * freq_hz[n]);
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  // Reference model: phases timed by absolute cycle stamps.
  typedef struct {
    int          idx;
    int unsigned div;
  } strobe_t;

  strobe_t exp_q [$];
  int      m_phase  = 0;   // 0 silent/idle, 1 sounding, 2 pause
  longint  cyc      = 0;
  longint  m_start  = 0;
  int      m_note   = 0;
  bit      m_strobe = 1'b0;

  task automatic model_advance();
    strobe_t s;
    m_note   = (m_note + 1) % 8;
    m_strobe = 1'b1;
    s.idx    = m_note;
    s.div    = ref_div(m_note);
    exp_q.push_back(s);
  endtask

  always @(posedge inclk or posedge reset) begin
    if (reset) begin
      m_phase  = 0;
      m_note   = 0;
      m_strobe = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      m_strobe = 1'b0;
      if (m_phase == 0) begin
        if (play) begin
          m_phase = 1;
          m_start = cyc;
        end else if (next) begin
          model_advance();
        end
      end else if (!play) begin
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (next || (auto && (cyc - m_start) == NOTE_CYC)) begin
          m_phase = 2;
          m_start = cyc;
        end
      end else if ((cyc - m_start) == GAP_CYC) begin
        model_advance();
        m_phase = 1;
        m_start = cyc;
      end
    end
  end

  // Monitor: compare every cycle, pop the scoreboard on each strobe.
  always @(negedge inclk) begin
    if (!reset) begin
      strobe_t s;
      check("mon_tone_en", tone_en, (m_phase == 1) ? 1 : 0);
      check("mon_note_idx", note_idx, m_note);
      check("mon_div", div_clk_count, ref_div(m_note));
      check("mon_strobe", note_strobe, m_strobe);
      if (note_strobe) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_strobe: got strobe idx %0d, expected none", note_idx);
        end else begin
          s = exp_q.pop_front();
          check("sb_idx", note_idx, s.idx);
          check("sb_div", div_clk_count, s.div);
        end
      end
    end
  end

  initial begin
    int cnt;
    int saved;

    // Reset state
    repeat (3) @(posedge inclk);
    #4 reset = 1'b0;
    tick();
    check("rst_idx", note_idx, 0);
    check("rst_div", div_clk_count, 47801);
    check("rst_tone", tone_en, 0);
    check("rst_strobe", note_strobe, 0);

    // Auto-advance timing
    play = 1'b1;
    auto = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("auto_tone_on", tone_en, 1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("auto_gap_tone", tone_en, 0);
      check("auto_gap_strobe", note_strobe, 0);
    end
    tick();
    check("auto_idx", note_idx, 1);
    check("auto_div", div_clk_count, spec_div[1]);
    check("auto_strobe", note_strobe, 1);
    tick();
    check("auto_strobe_once", note_strobe, 0);

    // Return to idle and clear the index with a mid-cycle reset pulse
    play = 1'b0;
    auto = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();

    // Manual stepping in IDLE
    for (int k = 1; k <= 8; k++) begin
      next = 1'b1;
      tick();
      check("man_strobe", note_strobe, 1);
      check("man_idx", note_idx, k % 8);
      check("man_div", div_clk_count, spec_div[k % 8]);
      next = 1'b0;
      tick();
      check("man_strobe_low", note_strobe, 0);
      tick();
      check("man_strobe_low", note_strobe, 0);
    end
    check("man_final_div", div_clk_count, 47801);

    // Manual advance from PLAY with auto off
    play = 1'b1;
    tick();
    repeat (4) tick();
    check("next_play_tone", tone_en, 1);
    next = 1'b1;
    tick();
    next = 1'b0;
    check("next_tone_off", tone_en, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("next_gap_tone", tone_en, 0);
    end
    tick();
    check("next_idx", note_idx, 1);
    check("next_strobe", note_strobe, 1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (note_strobe || !tone_en) cnt++;
    end
    check("no_auto_advance", cnt, 0);
    check("no_auto_idx", note_idx, 1);

    // play dropped in GAP cycle 2
    next = 1'b1;
    tick();
    next = 1'b0;
    tick();
    play = 1'b0;
    tick();
    check("gap_abort_tone", tone_en, 0);
    check("gap_abort_idx", note_idx, 1);
    check("gap_abort_strobe", note_strobe, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (note_strobe) cnt++;
    end
    check("gap_abort_no_strobe", cnt, 0);
    play = 1'b1;
    auto = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tone_en) cnt++;
      else if (cnt > 0) break;
    end
    check("replay_full_len", cnt, 20);
    check("replay_idx", note_idx, 1);

    // play=0 and next together in PLAY
    cnt = 0;
    while (!tone_en && cnt < 10) begin
      tick();
      cnt++;
    end
    check("wait_tone", tone_en, 1);
    saved = note_idx;
    play = 1'b0;
    next = 1'b1;
    auto = 1'b0;
    tick();
    next = 1'b0;
    check("drop_tone", tone_en, 0);
    check("drop_idx", note_idx, saved);
    check("drop_strobe", note_strobe, 0);
    tick();
    check("drop_strobe_after", note_strobe, 0);
    check("drop_idx_after", note_idx, saved);

    // Async reset mid-PLAY at note 5
    for (int i = 0; i < 8; i++) begin
      if (note_idx == 3'd5) break;
      next = 1'b1;
      tick();
      next = 1'b0;
      tick();
    end
    check("pre_rst_idx", note_idx, 5);
    play = 1'b1;
    repeat (3) tick();
    check("pre_rst_tone", tone_en, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_idx", note_idx, 0);
    check("async_rst_div", div_clk_count, 47801);
    check("async_rst_tone", tone_en, 0);
    check("async_rst_strobe", note_strobe, 0);
    play = 1'b0;
    @(posedge inclk);
    #3 reset = 1'b0;
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      play = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 49) == 0) auto = ~auto;
      next = ($urandom_range(0, 9) == 0);
      tick();
    end
    play = 1'b0;
    next = 1'b0;
    repeat (3) tick();
    check("sb_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
